// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Initiator side of the data-memory port. It accepts one load or store from
// the EX/MEM stage and checks its range and alignment. A legal request drives
// the memory strobes, address and write data for LATENCY cycles. The pipeline
// is stalled for the whole access. The access ends with a one-cycle done pulse,
// and err is set on that pulse when the request was rejected.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_read, req_write   load / store request from the pipeline
//   req_addr, req_wdata   byte address and store data
//   stall                 freeze the pipeline
//   done, err             completion pulse; err is valid only while done=1
//   rdata                 last successful load result
//   mem_read, mem_write   registered memory strobes
//   mem_address           registered req_addr[15:0]
//   mem_writedata         registered store data
//   mem_readdata          data returned by the memory
module mem_access_ctrl #(
    parameter int ADDR_BASE = 1024,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [31:0] BASE  = 32'(ADDR_BASE);
    localparam logic [31:0] WORDS = 32'(DEPTH);
    localparam logic [3:0]  LAST  = 4'(LATENCY - 1);

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic        err_q;
    logic        req_any;
    logic        req_valid;
    logic [31:0] offset;
    logic        last_cycle;

    assign req_any    = req_read | req_write;
    assign offset     = req_addr - BASE;
    // The offset is only meaningful when req_addr >= BASE. The lower-bound
    // term masks the wrapped value, so the subtraction cannot wrap into range.
    assign req_valid  = !(req_read && req_write) && (req_addr[1:0] == 2'b00) &&
                        (req_addr >= BASE) && ((offset >> 2) < WORDS);
    assign last_cycle = (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together at the edge, with no dependence on
    // the order in which processes are evaluated.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every output of this block gets a default before the case. Every
    // path then assigns every signal, and no latch is inferred.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                // A request held across reset must not freeze the pipeline.
                stall = req_any & ~rst;
                if (req_any) next_state = req_valid ? ACCESS : DONE;
            end
            ACCESS: begin
                stall = 1'b1;
                if (last_cycle) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                err        = err_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            err_q         <= 1'b0;
            rdata         <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        cnt           <= '0;
                        err_q         <= !req_valid;
                        mem_address   <= req_addr[15:0];
                        mem_writedata <= req_wdata;
                        // The strobes hold the latched operation, and they
                        // are never raised for a rejected request.
                        mem_read      <= req_valid & req_read;
                        mem_write     <= req_valid & req_write;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (last_cycle) begin
                        if (mem_read) rdata <= mem_readdata;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. A behavioural reference decides
// legality and latency for each request from plain address arithmetic. A
// reference array tracks what each load must return.
module tb_mem_access_ctrl;

    localparam int LAT  = 3;
    localparam int BASE = 1024;
    localparam int DEP  = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic        mem_read, mem_write;
    logic [15:0] mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] ref_mem [DEP];
    logic [31:0] dev_mem [DEP];
    logic [31:0] exp_rdata;
    logic [15:0] dev_off;
    logic [7:0]  dev_idx;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_BASE(BASE), .DEPTH(DEP), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .err(err), .rdata(rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata)
    );

    // Behavioural data memory: translates the byte address to a word index.
    assign dev_off      = mem_address - 16'h0400;
    assign dev_idx      = dev_off[9:2];
    assign mem_readdata = dev_mem[dev_idx];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < DEP; i++) dev_mem[i] <= ref_mem[i];
        end else if (mem_write) begin
            dev_mem[dev_idx] <= mem_writedata;
        end
    end

    function automatic bit addr_ok(input logic rd, input logic wr, input logic [31:0] a);
        longint la;
        la = longint'(a);
        return !(rd && wr) && (la % 4 == 0) && (la >= BASE) && ((la - BASE) / 4 < DEP);
    endfunction

    // Presents one request (called just after a posedge) and holds it like a
    // stalled pipeline until the done cycle has passed. Every cycle is checked
    // against the expected timeline. Returns the cycle of the request and of
    // the done pulse.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input string name,
                           output int t_req, output int t_done);
        bit   valid;
        int   done_at;
        logic [4:0] got, want;
        valid   = addr_ok(rd, wr, addr);
        done_at = valid ? LAT + 1 : 1;
        req_read  = rd;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        t_req  = cyc;
        t_done = -1;
        for (int c = 0; c <= done_at; c++) begin
            @(negedge clk);
            want = {(c == 0) || (valid && c <= LAT),
                    c == done_at,
                    (c == done_at) && !valid,
                    valid && rd && c >= 1 && c <= LAT,
                    valid && wr && c >= 1 && c <= LAT};
            got  = {stall, done, err, mem_read, mem_write};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s cycle %0d {stall,done,err,rd,wr}: got %b want %b", name, c, got, want);
            end
            if (valid && c >= 1 && c <= LAT) begin
                n_checks++;
                if (mem_address !== addr[15:0] || (wr && mem_writedata !== wdata)) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d addr/data: got %h/%h want %h/%h",
                             name, c, mem_address, mem_writedata, addr[15:0], wdata);
                end
            end
            if (c == done_at) begin
                t_done = cyc;
                if (valid && rd) exp_rdata = ref_mem[(addr - BASE) >> 2];
                if (valid && wr) ref_mem[(addr - BASE) >> 2] = wdata;
                n_checks++;
                if (rdata !== exp_rdata) begin
                    n_fail++;
                    $display("FAIL %s rdata at done: got %h want %h", name, rdata, exp_rdata);
                end
            end
        end
        @(posedge clk);
        #1;
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_read = 1'b1; req_write = 1'b0;
        req_addr = 32'd1028; req_wdata = 32'h1234_5678;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({stall, done, err, mem_read, mem_write, mem_address, mem_writedata, rdata} !== '0) begin
                n_fail++;
                $display("FAIL reset outputs: stall=%b done=%b err=%b rd=%b wr=%b addr=%h wd=%h rdata=%h",
                         stall, done, err, mem_read, mem_write, mem_address, mem_writedata, rdata);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_read = 1'b0;
        exp_rdata = '0;
        @(negedge clk);
        n_checks++;
        if ({stall, done, mem_read, mem_write} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle after reset: got %b want 0000", {stall, done, mem_read, mem_write});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        int tr, td;
        run_txn(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, "store_1028", tr, td);
        run_txn(1'b1, 1'b0, 32'd1028, 32'h0, "load_1028", tr, td);
        n_checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL load_value: got %h want deadbeef", rdata);
        end
        run_txn(1'b0, 1'b1, 32'd1032, 32'h0BAD_F00D, "store_1032", tr, td);
        n_checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL rdata_after_store: got %h want deadbeef", rdata);
        end
        // Highest legal word.
        run_txn(1'b0, 1'b1, 32'd2044, 32'hA5A5_5A5A, "store_top", tr, td);
        run_txn(1'b1, 1'b0, 32'd2044, 32'h0, "load_top", tr, td);
    endtask

    task automatic test_reject();
        int tr, td;
        run_txn(1'b1, 1'b0, 32'd1030, 32'h1, "rej_misaligned", tr, td);
        run_txn(1'b0, 1'b1, 32'd1020, 32'h2, "rej_below", tr, td);
        run_txn(1'b1, 1'b0, 32'd2048, 32'h3, "rej_above", tr, td);
        run_txn(1'b1, 1'b1, 32'd1028, 32'h4, "rej_both", tr, td);
    endtask

    task automatic test_reset_mid();
        int tr, td;
        req_read = 1'b1; req_write = 1'b0; req_addr = 32'd1032; req_wdata = '0;
        @(negedge clk);                       // cycle T
        @(posedge clk); @(negedge clk);       // cycle T+1
        n_checks++;
        if (mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst strobe T+1: got %b want 1", mem_read);
        end
        @(posedge clk); #1; rst = 1'b1;       // cycle T+2
        @(posedge clk); #1; rst = 1'b0; req_read = 1'b0;
        exp_rdata = '0;
        for (int c = 3; c < 3 + LAT + 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_read, done, stall} !== 3'b000 || rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL midrst cycle T+%0d: rd=%b done=%b stall=%b rdata=%h want 0",
                         c, mem_read, done, stall, rdata);
            end
            @(posedge clk); #1;
        end
        run_txn(1'b1, 1'b0, 32'd1032, '0, "load_after_rst", tr, td);
    endtask

    task automatic test_back_to_back();
        int tr1, td1, tr2, td2;
        run_txn(1'b1, 1'b0, 32'd1024, '0, "b2b_load", tr1, td1);
        run_txn(1'b0, 1'b1, 32'd1028, 32'hC0FF_EE00, "b2b_store", tr2, td2);
        n_checks++;
        if (td1 - tr1 != LAT + 1 || tr2 - tr1 != LAT + 2 || td2 - td1 != LAT + 2) begin
            n_fail++;
            $display("FAIL b2b spacing: done1=T+%0d start2=T+%0d done2=T+%0d want T+4/T+5/T+9",
                     td1 - tr1, tr2 - tr1, td2 - tr1);
        end
    endtask

    task automatic test_random();
        int tr, td;
        logic rd, wr;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = 32'(BASE + 4 * $urandom_range(0, DEP - 1));
                6: a = 32'(BASE + $urandom_range(0, 4 * DEP - 1));
                7: a = 32'($urandom_range(0, BASE - 1));
                8: a = 32'(BASE + 4 * DEP + $urandom_range(0, 4096));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin rd = 1'b1; wr = 1'b0; end
                4, 5, 6, 7, 8: begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            run_txn(rd, wr, a, $urandom, "random", tr, td);
        end
    endtask

    initial begin
        for (int i = 0; i < DEP; i++) ref_mem[i] = $urandom;
        exp_rdata = '0;
        test_reset();
        test_store_load();
        test_reject();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator side of the data-memory port. Sits between the EX/MEM pipeline register and the 256-word data memory (read/write strobes, 16-bit address, 32-bit data). It accepts one load/store request from the pipeline, range- and alignment-checks it, and drives the memory strobes for a fixed number of cycles. It stalls the pipeline for the whole access, then returns load data with a one-cycle done pulse.

Parameters:
ADDR_BASE, 1024, byte address of data-memory word 0
DEPTH, 256, number of 32-bit words in data memory
LATENCY, 3, cycles the strobes/address/data must be held per access (legal range 1..15)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
req_read  input  1  pipeline load request
req_write  input  1  pipeline store request
req_addr  input  32  byte address from ALU
req_wdata  input  32  store data
stall  output  1  freeze pipeline
done  output  1  one-cycle completion pulse
err  output  1  access rejected; valid only while done=1
rdata  output  32  load result; holds value until the next successful load
mem_read  output  1  memory read strobe, registered
mem_write  output  1  memory write strobe, registered
mem_address  output  16  req_addr[15:0], unmodified; the memory translates it; registered
mem_writedata  output  32  latched req_wdata; registered
mem_readdata  input  32  memory read data

Behaviour:
- Reset (rst sampled high at posedge): state=IDLE, cnt=0. stall, done, err, rdata, mem_read, mem_write, mem_address and mem_writedata all go to 0 on the next cycle.
- Reset has priority over every other event, including mid-ACCESS. An aborted access produces no done pulse and leaves rdata unchanged from its reset value.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - stall = req_read | req_write, combinational.
  - On a request, latch the operation, req_addr and req_wdata, then run the validity check.
  - Request is invalid if any of these holds:
    - req_read and req_write are both asserted.
    - req_addr[1:0] != 0.
    - req_addr < ADDR_BASE.
    - (req_addr - ADDR_BASE) >> 2 >= DEPTH. Compute in 32 bits, no wrap.
  - Valid request: go to ACCESS, cnt=0, and assert the matching registered strobe with mem_address/mem_writedata.
  - Invalid request: go to DONE with err=1; no strobe is ever asserted.
- ACCESS:
  - stall=1.
  - The strobe, mem_address and mem_writedata are held constant for exactly LATENCY cycles.
  - cnt increments each cycle. At cnt==LATENCY-1:
    - For a read, rdata <= mem_readdata.
    - Strobes drop to 0 next cycle and the state goes to DONE.
  - req_* inputs are ignored in ACCESS.
- DONE:
  - stall=0, done=1 for one cycle, err as determined; then return to IDLE unconditionally.
  - req_* are ignored in DONE, because the pipeline still presents the same instruction in this cycle.
- Timing, with the request first seen in IDLE at cycle T:
  - Valid access: strobes high in T+1..T+LATENCY; stall high in T..T+LATENCY; done at T+LATENCY+1.
  - Invalid access: stall at T only; done=err=1 at T+1.
- Writes and errors never modify rdata.
- Back-to-back requests: the next request is accepted in the IDLE cycle immediately after DONE. Minimum spacing is LATENCY+2 cycles.
- mem_write is asserted for LATENCY consecutive edges with identical address and data; the memory must tolerate the repeated writes.

Test Plan:
- Reset: assert rst 2 cycles with a request pending -> all outputs 0; state IDLE; no strobes.
- Store, LATENCY=3: req_write, req_addr=1028, req_wdata=0xDEADBEEF at T -> mem_write=1 with mem_address=0x0404 and mem_writedata=0xDEADBEEF in T+1..T+3; stall in T..T+3; done=1, err=0 at T+4; rdata unchanged.
- Load of the same address, with the bench memory returning 0xDEADBEEF -> mem_read in T+1..T+3; rdata=0xDEADBEEF and done at T+4. rdata still 0xDEADBEEF after a following store to 1032.
- Rejections, each run separately:
  - req_addr=1030
  - req_addr=1020
  - req_addr=2048
  - req_read and req_write both asserted at 1028
  -> each gives stall at T only, done=err=1 at T+1, mem_read/mem_write never high.
- Reset mid-access: load at T, rst at T+2 -> mem_read=0 from T+3; no done pulse; rdata=0; the next load completes normally.
- Back-to-back: load 1024 then store 1028 held by a stalling pipeline model -> second access starts at T+5; done pulses at T+4 and T+9.
